// File: rtl/branch_pc_sequencer.sv
// Multicycle PC sequencer: fetches over req/ack, feeds the branch unit, commits the resolved PC.
// 4 cycles per instruction plus 1 per ack-wait cycle; a fetch stalls on imem_ack and traps after ACK_TIMEOUT.
module branch_pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] iaddr,
  input  logic        imem_ack,
  input  logic [31:0] idata,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [31:0] br_instr,
  output logic [31:0] br_pc,
  input  logic [31:0] br_next_pc,
  output logic [31:0] pc,
  output logic        retire,
  output logic        branch_taken,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] retire_cnt,
  output logic [31:0] taken_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_TRAP
  } state_t;

  localparam logic [7:0]  TMO_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [1:0]  CAUSE_TMO = 2'b01;
  localparam logic [1:0]  CAUSE_F3  = 2'b10;
  localparam logic [1:0]  CAUSE_MIS = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic        taken_q, taken_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  logic [31:0] pc_plus4;
  logic        is_branch;
  logic        bad_f3;
  logic [31:0] exec_next;
  logic        exec_taken;

  assign pc_plus4   = pc_q + 32'd4;
  assign is_branch  = (ir_q[6:0] == OP_BRANCH);
  assign bad_f3     = (ir_q[14:12] == 3'b010) || (ir_q[14:12] == 3'b011);
  assign exec_next  = is_branch ? br_next_pc : pc_plus4;
  // A branch landing on pc+4 is indistinguishable from fall-through, so it is not counted as taken.
  assign exec_taken = is_branch && (br_next_pc != pc_plus4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= 32'd0;
      next_pc_q    <= 32'd0;
      taken_q      <= 1'b0;
      tmo_q        <= 8'd0;
      cause_q      <= 2'b00;
      retire_cnt_q <= 32'd0;
      taken_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      next_pc_q    <= next_pc_d;
      taken_q      <= taken_d;
      tmo_q        <= tmo_d;
      cause_q      <= cause_d;
      retire_cnt_q <= retire_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    next_pc_d    = next_pc_q;
    taken_d      = taken_q;
    tmo_d        = tmo_q;
    cause_d      = cause_q;
    retire_cnt_d = retire_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          tmo_d   = 8'd0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = idata;
          tmo_d   = 8'd0;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TMO;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_branch && bad_f3) begin
          state_d = S_TRAP;
          cause_d = CAUSE_F3;
        end else if (exec_next[1:0] != 2'b00) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MIS;
        end else begin
          next_pc_d = exec_next;
          taken_d   = exec_taken;
          state_d   = S_UPDATE;
        end
      end
      S_UPDATE: begin
        pc_d         = next_pc_q;
        retire_cnt_d = retire_cnt_q + 32'd1;
        taken_cnt_d  = taken_cnt_q + {31'd0, taken_q};
        tmo_d        = 8'd0;
        state_d      = halt_req ? S_IDLE : S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req     = (state_q == S_FETCH);
  assign iaddr        = pc_q;
  assign rs1_addr     = ir_q[19:15];
  assign rs2_addr     = ir_q[24:20];
  assign br_instr     = (state_q == S_EXEC) ? ir_q : 32'd0;
  assign br_pc        = (state_q == S_EXEC) ? pc_q : 32'd0;
  assign pc           = pc_q;
  assign retire       = (state_q == S_UPDATE);
  assign branch_taken = (state_q == S_UPDATE) && taken_q;
  assign trap         = (state_q == S_TRAP);
  assign trap_cause   = cause_q;
  assign retire_cnt   = retire_cnt_q;
  assign taken_cnt    = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Bench for branch_pc_sequencer: acts as instruction memory and branch unit, checks against an ISA-level model.
module tb_branch_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          ACK_TO   = 16;

  logic        clk = 1'b0;
  logic        rst_n, start, halt_req, imem_ack;
  logic [31:0] idata, br_next_pc;
  logic        imem_req, retire, branch_taken, trap;
  logic [31:0] iaddr, br_instr, br_pc, pc, retire_cnt, taken_cnt;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [1:0]  trap_cause;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [31:0] m_tak;

  branch_pc_sequencer #(.RESET_PC(RESET_PC), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .iaddr(iaddr), .imem_ack(imem_ack), .idata(idata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .br_instr(br_instr), .br_pc(br_pc),
    .br_next_pc(br_next_pc), .pc(pc), .retire(retire), .branch_taken(branch_taken),
    .trap(trap), .trap_cause(trap_cause), .retire_cnt(retire_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Architectural effect of one instruction: cause 0 means it commits.
  function automatic void ref_exec(input logic [31:0] p, input logic [31:0] instr,
                                   input logic [31:0] tgt, output logic [1:0] cause,
                                   output logic [31:0] nxt, output logic tk);
    cause = 2'b00;
    nxt   = p + 32'd4;
    tk    = 1'b0;
    if (instr[6:0] == 7'h63) begin
      if (instr[14:12] == 3'd2 || instr[14:12] == 3'd3) cause = 2'b10;
      else begin
        nxt = tgt;
        tk  = (tgt != p + 32'd4);
      end
    end
    if (cause == 2'b00 && nxt[1:0] != 2'b00) cause = 2'b11;
  endfunction

  function automatic logic [31:0] mk_instr(input bit branch, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    if (branch) begin
      r[6:0] = 7'h63;
      r[14:12] = f3;
    end else begin
      case ($urandom_range(0, 3))
        0: r[6:0] = 7'h13;
        1: r[6:0] = 7'h33;
        2: r[6:0] = 7'h03;
        default: r[6:0] = 7'h6F;
      endcase
    end
    return r;
  endfunction

  function automatic logic [2:0] legal_f3();
    logic [2:0] f;
    f = 3'($urandom_range(0, 5));
    if (f >= 3'd2) f = f + 3'd2;
    return f;
  endfunction

  task automatic model_reset();
    m_pc  = RESET_PC;
    m_ret = 0;
    m_tak = 0;
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at a negedge in FETCH, IDLE or TRAP.
  task automatic run_instr(input logic [31:0] instr, input logic [31:0] tgt,
                           input int wait_n, input bit halt);
    logic [1:0]  cause;
    logic [31:0] nxt;
    logic        tk;
    bit          hold_ok, ret_ok;
    ref_exec(m_pc, instr, tgt, cause, nxt, tk);
    br_next_pc = tgt;
    hold_ok = 1;
    ret_ok  = 1;
    for (int w = 0; w < wait_n && w < ACK_TO; w++) begin
      if (imem_req !== 1'b1 || iaddr !== m_pc) hold_ok = 0;
      if (retire !== 1'b0) ret_ok = 0;
      imem_ack = 1'b0;
      idata    = $urandom;
      start    = 1'($urandom);
      halt_req = 1'($urandom);
      @(negedge clk);
    end
    if (wait_n >= ACK_TO) begin
      tests++;
      if (!hold_ok) $display("FAIL fetch_hold_tmo: iaddr/imem_req not held at pc=%h", m_pc);
      if (!hold_ok) fails++;
      tests++;
      if (trap !== 1'b1 || trap_cause !== 2'b01 || imem_req !== 1'b0 || pc !== m_pc) begin
        fails++;
        $display("FAIL timeout_trap: trap=%b cause=%b req=%b pc=%h, want 1 01 0 %h",
                 trap, trap_cause, imem_req, pc, m_pc);
      end
      start = 0; halt_req = 0;
      return;
    end
    if (imem_req !== 1'b1 || iaddr !== m_pc) hold_ok = 0;
    imem_ack = 1'b1;
    idata    = instr;
    @(negedge clk);
    tests++;
    if (!hold_ok) begin
      fails++;
      $display("FAIL fetch_hold: iaddr=%h req=%b, want %h 1 throughout fetch", iaddr, imem_req, m_pc);
    end
    if (retire !== 1'b0) ret_ok = 0;
    imem_ack = 1'($urandom); idata = $urandom; start = 1'($urandom); halt_req = 1'($urandom);
    @(negedge clk);
    tests++;
    if (br_instr !== instr || br_pc !== m_pc || rs1_addr !== instr[19:15] || rs2_addr !== instr[24:20]) begin
      fails++;
      $display("FAIL exec_drive: br_instr=%h br_pc=%h rs1=%0d rs2=%0d, want %h %h %0d %0d",
               br_instr, br_pc, rs1_addr, rs2_addr, instr, m_pc, instr[19:15], instr[24:20]);
    end
    if (retire !== 1'b0) ret_ok = 0;
    imem_ack = 1'($urandom); idata = $urandom; start = 1'($urandom); halt_req = 1'($urandom);
    @(negedge clk);
    if (cause != 2'b00) begin
      tests++;
      if (trap !== 1'b1 || trap_cause !== cause || pc !== m_pc || imem_req !== 1'b0 || retire !== 1'b0) begin
        fails++;
        $display("FAIL exec_trap: trap=%b cause=%b pc=%h req=%b retire=%b, want 1 %b %h 0 0",
                 trap, trap_cause, pc, imem_req, retire, cause, m_pc);
      end
      imem_ack = 0; start = 0; halt_req = 0;
      return;
    end
    tests++;
    if (retire !== 1'b1 || branch_taken !== tk || !ret_ok) begin
      fails++;
      $display("FAIL commit: retire=%b taken=%b early_retire=%b, want 1 %b 0 (%0d wait cycles)",
               retire, branch_taken, !ret_ok, tk, wait_n);
    end
    m_pc  = nxt;
    m_ret = m_ret + 1;
    m_tak = m_tak + {31'd0, tk};
    halt_req = halt; start = 1'($urandom); imem_ack = 1'($urandom);
    @(negedge clk);
    tests++;
    if (pc !== m_pc || retire !== 1'b0 || retire_cnt !== m_ret || taken_cnt !== m_tak ||
        imem_req !== !halt) begin
      fails++;
      $display("FAIL post_commit: pc=%h retire=%b rcnt=%0d tcnt=%0d req=%b, want %h 0 %0d %0d %b",
               pc, retire, retire_cnt, taken_cnt, imem_req, m_pc, m_ret, m_tak, !halt);
    end
    halt_req = 0; start = 0; imem_ack = 0;
  endtask

  task automatic kick();
    start = 1'b1;
    imem_ack = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ack = 1'b1;
    #2;
    model_reset();
    tests++;
    if (pc !== RESET_PC || imem_req !== 1'b0 || trap !== 1'b0 || retire_cnt !== 0 || taken_cnt !== 0) begin
      fails++;
      $display("FAIL reset_values: pc=%h req=%b trap=%b rcnt=%0d tcnt=%0d", pc, imem_req, trap,
               retire_cnt, taken_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b0;
  endtask

  task automatic check_trap_hold(input logic [1:0] cause);
    bit ok = 1;
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; imem_ack = 1'($urandom); halt_req = 1'($urandom);
      @(negedge clk);
      if (trap !== 1'b1 || trap_cause !== cause || imem_req !== 1'b0 || pc !== m_pc || retire !== 1'b0)
        ok = 0;
    end
    start = 0; imem_ack = 0; halt_req = 0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL trap_sticky: trap=%b cause=%b req=%b pc=%h, want 1 %b 0 %h",
               trap, trap_cause, imem_req, pc, cause, m_pc);
    end
  endtask

  task automatic test_reset();
    #3;
    model_reset();
    tests++;
    if (pc !== RESET_PC || iaddr !== RESET_PC || imem_req || retire || branch_taken || trap ||
        trap_cause !== 0 || retire_cnt !== 0 || taken_cnt !== 0 || rs1_addr !== 0 || rs2_addr !== 0 ||
        br_instr !== 0 || br_pc !== 0) begin
      fails++;
      $display("FAIL reset_outputs: pc=%h iaddr=%h req=%b retire=%b trap=%b br_instr=%h br_pc=%h",
               pc, iaddr, imem_req, retire, trap, br_instr, br_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit ok = 1;
      for (int i = 0; i < 10; i++) begin
        imem_ack = 1'($urandom); halt_req = 1'($urandom);
        @(negedge clk);
        if (pc !== RESET_PC || imem_req !== 1'b0 || retire !== 1'b0 || retire_cnt !== 0 || taken_cnt !== 0)
          ok = 0;
      end
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL idle_hold: pc=%h req=%b retire=%b rcnt=%0d, want %h 0 0 0",
                 pc, imem_req, retire, retire_cnt, RESET_PC);
      end
    end
    imem_ack = 0; halt_req = 0;
  endtask

  task automatic test_sequential();
    kick();
    for (int i = 0; i < 3; i++) run_instr(32'h0010_0093 | (32'(i) << 20), 32'hDEAD_BEEF, 0, 0);
    tests++;
    if (pc !== 32'h0000_000C || retire_cnt !== 32'd3 || taken_cnt !== 32'd0) begin
      fails++;
      $display("FAIL seq_flow: pc=%h rcnt=%0d tcnt=%0d, want 0000000c 3 0", pc, retire_cnt, taken_cnt);
    end
  endtask

  task automatic test_branch();
    run_instr(mk_instr(1, 3'b000), 32'h0000_0100, 0, 0);
    run_instr(mk_instr(1, 3'b000), 32'h0000_0FF8, 1, 0);
    run_instr(mk_instr(1, 3'b001), 32'h0000_0FFC, 0, 0);
    tests++;
    if (pc !== 32'h0000_0FFC || taken_cnt !== 32'd2) begin
      fails++;
      $display("FAIL branch_counts: pc=%h tcnt=%0d, want 00000ffc 2", pc, taken_cnt);
    end
  endtask

  task automatic test_wait_states();
    run_instr(mk_instr(0, 3'b000), 32'h0, 3, 0);
    run_instr(mk_instr(1, legal_f3()), m_pc + 32'd64, 5, 0);
  endtask

  task automatic test_pc_wrap();
    run_instr(mk_instr(1, 3'b100), 32'hFFFF_FFFC, 0, 0);
    run_instr(mk_instr(0, 3'b000), 32'h0000_0040, 0, 0);
    tests++;
    if (pc !== 32'h0000_0000) begin
      fails++;
      $display("FAIL pc_wrap: pc=%h, want 00000000", pc);
    end
  endtask

  task automatic test_halt();
    bit ok = 1;
    run_instr(mk_instr(0, 3'b000), 32'h0, 2, 1);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'($urandom); halt_req = 1'($urandom);
      @(negedge clk);
      if (imem_req !== 1'b0 || retire !== 1'b0 || pc !== m_pc) ok = 0;
    end
    imem_ack = 0; halt_req = 0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL halt_idle: req=%b retire=%b pc=%h, want 0 0 %h", imem_req, retire, pc, m_pc);
    end
    kick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit          br;
      logic [31:0] tgt;
      br = 1'($urandom);
      case ($urandom_range(0, 2))
        0: tgt = m_pc + 32'd4;
        1: tgt = $urandom & 32'hFFFF_FFFC;
        default: tgt = m_pc - (32'($urandom_range(1, 64)) << 2);
      endcase
      run_instr(mk_instr(br, legal_f3()), tgt, $urandom_range(0, 5), ($urandom_range(0, 5) == 0));
      if (imem_req !== 1'b1) kick();
    end
  endtask

  task automatic test_timeout();
    run_instr(mk_instr(0, 3'b000), 32'h0, ACK_TO, 0);
    check_trap_hold(2'b01);
  endtask

  task automatic test_illegal_f3();
    do_reset();
    kick();
    run_instr(mk_instr(1, 3'b000), 32'h0000_0100, 0, 0);
    run_instr(mk_instr(1, 3'b010), 32'h0000_0200, 1, 0);
    check_trap_hold(2'b10);
  endtask

  task automatic test_misaligned();
    do_reset();
    kick();
    run_instr(mk_instr(1, 3'b101), 32'h0000_0100, 0, 0);
    run_instr(mk_instr(1, 3'b000), 32'h0000_0102, 0, 0);
    check_trap_hold(2'b11);
  endtask

  task automatic test_async_reset();
    do_reset();
    kick();
    run_instr(mk_instr(0, 3'b000), 32'h0, 0, 0);
    run_instr(mk_instr(1, 3'b000), 32'h0000_0200, 0, 0);
    imem_ack = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    imem_ack = 1'b1;
    idata = $urandom;
    #1;
    model_reset();
    tests++;
    if (pc !== RESET_PC || imem_req !== 1'b0 || retire_cnt !== 0 || taken_cnt !== 0 || trap !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: pc=%h req=%b rcnt=%0d tcnt=%0d trap=%b, want %h 0 0 0 0",
               pc, imem_req, retire_cnt, taken_cnt, trap, RESET_PC);
    end
    #7;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b0 || pc !== RESET_PC || rs1_addr !== 0 || rs2_addr !== 0) begin
      fails++;
      $display("FAIL reset_release: req=%b pc=%h rs1=%0d rs2=%0d, want 0 %h 0 0",
               imem_req, pc, rs1_addr, rs2_addr, RESET_PC);
    end
    imem_ack = 1'b0;
    kick();
    run_instr(mk_instr(0, 3'b000), 32'h0, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
    idata = 32'd0; br_next_pc = 32'd0;
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_wait_states();
    test_pc_wrap();
    test_halt();
    test_random();
    test_timeout();
    test_illegal_f3();
    test_misaligned();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
